// File: rtl/sat_engine_pkg.sv
// Shared types and constants for the SAT engine backtrack search:
// the find_bkt_ctrl FSM state type and the findflag encoding used on the
// chain between level-state cells.
package sat_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESULT = 2'd3
  } find_bkt_state_t;

  // findflag encoding carried left-to-right along the cell chain
  localparam logic [1:0] FF_NONE   = 2'd0;
  localparam logic [1:0] FF_HERE   = 2'd1;
  localparam logic [1:0] FF_PASSED = 2'd2;

endpackage

// File: rtl/or_reduce_vec.sv
// Bitwise OR of NUM packed WIDTH-bit words; word 0 sits in the LSBs.
module or_reduce_vec #(
  parameter int NUM   = 8,
  parameter int WIDTH = 16
) (
  input  logic [NUM*WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0]     or_o
);

  // fold every word into one accumulator
  always_comb begin
    or_o = '0;
    for (int i = 0; i < NUM; i++) begin
      or_o = or_o | vec_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/find_bkt_ctrl.sv
// Backtrack-search initiator. Broadcasts the max level to the level-state
// cells, waits for their registered bkt outputs, OR-collapses them (only the
// cell holding findflag==HERE drives a nonzero word) and reports the target
// or UNSAT, pulsing apply_bkt when a target exists.
module find_bkt_ctrl
  import sat_engine_pkg::*;
#(
  parameter int NUM_LVLS     = 8,
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [WIDTH_LVL-1:0]             max_lvl_i,
  output logic                             ready_o,
  output logic [WIDTH_LVL-1:0]             max_lvl_o,
  output logic [1:0]                       findflag_first_o,
  input  logic [1:0]                       findflag_last_i,
  input  logic [NUM_LVLS*WIDTH_BIN_ID-1:0] bkt_bin_all_i,
  input  logic [NUM_LVLS*WIDTH_LVL-1:0]    bkt_lvl_all_i,
  output logic                             apply_bkt_o,
  output logic                             done_o,
  output logic                             found_o,
  output logic                             unsat_o,
  output logic [WIDTH_BIN_ID-1:0]          bkt_bin_o,
  output logic [WIDTH_LVL-1:0]             bkt_lvl_o
);

  find_bkt_state_t         state_q, state_d;
  logic [WIDTH_LVL-1:0]    max_lvl_q, max_lvl_d;
  logic                    ready_q, ready_d;
  logic                    apply_q, apply_d;
  logic                    done_q, done_d;
  logic                    found_q, found_d;
  logic                    unsat_q, unsat_d;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;
  logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;

  logic [WIDTH_BIN_ID-1:0] bin_or;
  logic [WIDTH_LVL-1:0]    lvl_or;
  logic                    hit;

  or_reduce_vec #(.NUM(NUM_LVLS), .WIDTH(WIDTH_BIN_ID)) u_or_bin (
    .vec_i (bkt_bin_all_i),
    .or_o  (bin_or)
  );

  or_reduce_vec #(.NUM(NUM_LVLS), .WIDTH(WIDTH_LVL)) u_or_lvl (
    .vec_i (bkt_lvl_all_i),
    .or_o  (lvl_or)
  );

  assign hit = (findflag_last_i != FF_NONE);

  // next-state and registered-output computation for the search sequence
  always_comb begin
    state_d   = state_q;
    max_lvl_d = max_lvl_q;
    ready_d   = ready_q;
    apply_d   = 1'b0;
    done_d    = 1'b0;
    found_d   = found_q;
    unsat_d   = unsat_q;
    bkt_bin_d = bkt_bin_q;
    bkt_lvl_d = bkt_lvl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          max_lvl_d = max_lvl_i;
          found_d   = 1'b0;
          unsat_d   = 1'b0;
          bkt_bin_d = '0;
          bkt_lvl_d = '0;
          ready_d   = 1'b0;
          state_d   = ST_DRIVE;
        end
      end
      // cells register their bkt words at the end of this cycle
      ST_DRIVE: state_d = ST_SETTLE;
      ST_SETTLE: begin
        bkt_bin_d = bin_or;
        bkt_lvl_d = lvl_or;
        found_d   = hit;
        unsat_d   = ~hit;
        done_d    = 1'b1;
        apply_d   = hit;
        state_d   = ST_RESULT;
      end
      // max_lvl stays put here so cell findflags still match during apply
      ST_RESULT: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      max_lvl_q <= '0;
      ready_q   <= 1'b1;
      apply_q   <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      unsat_q   <= 1'b0;
      bkt_bin_q <= '0;
      bkt_lvl_q <= '0;
    end else begin
      state_q   <= state_d;
      max_lvl_q <= max_lvl_d;
      ready_q   <= ready_d;
      apply_q   <= apply_d;
      done_q    <= done_d;
      found_q   <= found_d;
      unsat_q   <= unsat_d;
      bkt_bin_q <= bkt_bin_d;
      bkt_lvl_q <= bkt_lvl_d;
    end
  end

  assign ready_o          = ready_q;
  assign max_lvl_o        = max_lvl_q;
  assign findflag_first_o = FF_NONE;
  assign apply_bkt_o      = apply_q;
  assign done_o           = done_q;
  assign found_o          = found_q;
  assign unsat_o          = unsat_q;
  assign bkt_bin_o        = bkt_bin_q;
  assign bkt_lvl_o        = bkt_lvl_q;

endmodule

// File: tb/tb_find_bkt_ctrl.sv
// Bench for find_bkt_ctrl: an abstract level-state list answers the
// controller, a latency/result model predicts every output each cycle.
module tb_find_bkt_ctrl;

  localparam int N  = 8;
  localparam int WL = 16;
  localparam int WB = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic [WL-1:0]     max_lvl_i = '0;
  logic              ready_o;
  logic [WL-1:0]     max_lvl_o;
  logic [1:0]        findflag_first_o;
  logic [1:0]        findflag_last_i;
  logic [N*WB-1:0]   bkt_bin_all_i;
  logic [N*WL-1:0]   bkt_lvl_all_i;
  logic              apply_bkt_o, done_o, found_o, unsat_o;
  logic [WB-1:0]     bkt_bin_o;
  logic [WL-1:0]     bkt_lvl_o;

  find_bkt_ctrl #(.NUM_LVLS(N), .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .max_lvl_i        (max_lvl_i),
    .ready_o          (ready_o),
    .max_lvl_o        (max_lvl_o),
    .findflag_first_o (findflag_first_o),
    .findflag_last_i  (findflag_last_i),
    .bkt_bin_all_i    (bkt_bin_all_i),
    .bkt_lvl_all_i    (bkt_lvl_all_i),
    .apply_bkt_o      (apply_bkt_o),
    .done_o           (done_o),
    .found_o          (found_o),
    .unsat_o          (unsat_o),
    .bkt_bin_o        (bkt_bin_o),
    .bkt_lvl_o        (bkt_lvl_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- abstract level-state list ----------------
  int  c_lvl [N];
  int  c_bin [N];
  bit  c_bkt [N];
  bit  c_use [N];
  int  ld_bin [N];
  bit  ld_bkt [N];
  bit  load_req = 0;
  bit  inj = 0;
  int  apply_cnt = 0;
  logic [WB-1:0] o_bin [N];
  logic [WL-1:0] o_lvl [N];

  // target = highest used level <= maxl that has not been backtracked yet
  function automatic int tgt(input int maxl);
    int best;
    best = -1;
    for (int i = 0; i < N; i++)
      if (c_use[i] && !c_bkt[i] && c_lvl[i] <= maxl &&
          (best < 0 || c_lvl[i] > c_lvl[best]))
        best = i;
    return best;
  endfunction

  always @(posedge clk) begin
    int t;
    t = tgt(int'(max_lvl_o));
    if (apply_bkt_o) apply_cnt <= apply_cnt + 1;
    for (int i = 0; i < N; i++) begin
      o_bin[i] <= (i == t && !inj) ? WB'(c_bin[i]) : '0;
      o_lvl[i] <= (i == t && !inj) ? WL'(c_lvl[i]) : '0;
    end
    if (inj) begin
      o_lvl[1] <= WL'(2);
      o_lvl[3] <= WL'(4);
    end
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        c_use[i] <= (i < 4);
        c_lvl[i] <= (i < 4) ? i + 1 : 0;
        c_bin[i] <= ld_bin[i];
        c_bkt[i] <= ld_bkt[i];
      end
    end else if (apply_bkt_o && !inj && t >= 0) begin
      c_bkt[t] <= 1'b1;
      for (int i = 0; i < N; i++)
        if (c_use[i] && c_lvl[i] > c_lvl[t] && c_lvl[i] <= int'(max_lvl_o)) begin
          c_bin[i] <= 0;
          c_bkt[i] <= 1'b0;
        end
    end
  end

  always_comb begin
    bkt_bin_all_i = '0;
    bkt_lvl_all_i = '0;
    for (int i = 0; i < N; i++) begin
      bkt_bin_all_i[i*WB +: WB] = o_bin[i];
      bkt_lvl_all_i[i*WL +: WL] = o_lvl[i];
    end
  end

  always_comb begin
    findflag_last_i = (tgt(int'(max_lvl_o)) >= 0) ? 2'd2 : 2'd0;
    if (inj) findflag_last_i = 2'd2;
  end

  // ---------------- controller model ----------------
  int            phase = 0;
  int            acc_cnt = 0;
  logic [WL-1:0] m_max = '0;
  logic          m_found = 0, m_unsat = 0;
  logic [WB-1:0] m_bin = '0;
  logic [WL-1:0] m_lvl = '0;
  logic          e_f = 0;
  logic [WB-1:0] e_bin = '0;
  logic [WL-1:0] e_lvl = '0;

  always @(posedge clk) begin
    int t;
    if (!rst) begin
      phase <= 0; m_max <= '0; m_found <= 0; m_unsat <= 0; m_bin <= '0; m_lvl <= '0;
    end else begin
      case (phase)
        0: if (start_i) begin
          phase <= 1; m_max <= max_lvl_i; acc_cnt <= acc_cnt + 1;
          m_found <= 0; m_unsat <= 0; m_bin <= '0; m_lvl <= '0;
          if (inj) begin
            e_f <= 1'b1; e_bin <= '0; e_lvl <= WL'(2) | WL'(4);
          end else begin
            t = tgt(int'(max_lvl_i));
            e_f <= (t >= 0);
            e_bin <= '0; e_lvl <= '0;
            if (t >= 0) begin
              e_bin <= WB'(c_bin[t]);
              e_lvl <= WL'(c_lvl[t]);
            end
          end
        end
        1: phase <= 2;
        2: begin
          phase <= 3; m_found <= e_f; m_unsat <= !e_f; m_bin <= e_bin; m_lvl <= e_lvl;
        end
        default: phase <= 0;
      endcase
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready_o), 32'(phase == 0));
      chk("done", 32'(done_o), 32'(phase == 3));
      chk("apply", 32'(apply_bkt_o), 32'(phase == 3 && m_found));
      chk("found", 32'(found_o), 32'(m_found));
      chk("unsat", 32'(unsat_o), 32'(m_unsat));
      chk("bkt_bin", 32'(bkt_bin_o), 32'(m_bin));
      chk("bkt_lvl", 32'(bkt_lvl_o), 32'(m_lvl));
      chk("max_lvl", 32'(max_lvl_o), 32'(m_max));
      chk("ff_first", 32'(findflag_first_o), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load_cells(input int b0, b1, b2, b3, input bit k0, k1, k2, k3);
    ld_bin = '{b0, b1, b2, b3, 0, 0, 0, 0};
    ld_bkt = '{k0, k1, k2, k3, 0, 0, 0, 0};
    load_req = 1;
    @(posedge clk); #1;
    load_req = 0;
  endtask

  task automatic go(input int maxl);
    start_i = 1; max_lvl_i = WL'(maxl);
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 10);
  endtask

  int n, a0;

  initial begin
    rst = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst = 1;

    // idle after reset
    repeat (5) @(posedge clk);
    #1;
    chk("t1_ready", 32'(ready_o), 32'd1);
    chk("t1_apply_cnt", 32'(apply_cnt), 32'd0);
    chk("t1_max", 32'(max_lvl_o), 32'd0);

    // found: levels 1..4 has_bkt {0,1,1,0}, max 3 -> level 1 bin 5
    load_cells(5, 7, 9, 3, 0, 1, 1, 0);
    go(3);
    wait_done(n);
    chk("t2_latency", 32'(n), 32'd3);
    chk("t2_lvl", 32'(bkt_lvl_o), 32'd1);
    chk("t2_bin", 32'(bkt_bin_o), 32'd5);
    chk("t2_found", 32'(found_o), 32'd1);
    chk("t2_apply", 32'(apply_bkt_o), 32'd1);
    @(posedge clk); #1;
    chk("t2_l1_bkt", 32'(c_bkt[0]), 32'd1);
    chk("t2_l1_bin", 32'(c_bin[0]), 32'd5);
    chk("t2_l2_bkt", 32'(c_bkt[1]), 32'd0);
    chk("t2_l2_bin", 32'(c_bin[1]), 32'd0);
    chk("t2_l3_bkt", 32'(c_bkt[2]), 32'd0);
    chk("t2_l3_bin", 32'(c_bin[2]), 32'd0);
    chk("t2_l4_bin", 32'(c_bin[3]), 32'd3);

    // unsat: everything already backtracked
    load_cells(5, 7, 9, 3, 1, 1, 1, 1);
    a0 = apply_cnt;
    go(4);
    wait_done(n);
    chk("t3_unsat", 32'(unsat_o), 32'd1);
    chk("t3_found", 32'(found_o), 32'd0);
    chk("t3_lvl", 32'(bkt_lvl_o), 32'd0);
    chk("t3_bin", 32'(bkt_bin_o), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("t3_no_apply", 32'(apply_cnt), 32'(a0));

    // start held high, max alternating 2/4 every 3 cycles
    load_cells(5, 7, 9, 3, 0, 1, 1, 0);
    a0 = acc_cnt;
    for (int k = 0; k < 20; k++) begin
      start_i = 1;
      max_lvl_i = ((k / 3) % 2 != 0) ? WL'(4) : WL'(2);
      @(posedge clk); #1;
    end
    start_i = 0;
    repeat (4) @(posedge clk); #1;
    chk("t4_accepts", 32'(acc_cnt - a0), 32'd5);

    // reset pulled during SETTLE
    load_cells(5, 7, 9, 3, 0, 1, 1, 0);
    a0 = apply_cnt;
    go(3);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    chk("t5_ready", 32'(ready_o), 32'd1);
    chk("t5_done", 32'(done_o), 32'd0);
    chk("t5_max", 32'(max_lvl_o), 32'd0);
    repeat (4) @(posedge clk); #1;
    chk("t5_no_apply", 32'(apply_cnt), 32'(a0));
    chk("t5_l1_bkt", 32'(c_bkt[0]), 32'd0);
    chk("t5_l3_bkt", 32'(c_bkt[2]), 32'd1);
    chk("t5_l3_bin", 32'(c_bin[2]), 32'd9);

    // protocol violation: two cells drive nonzero levels 2 and 4
    $display("note: injecting two simultaneous bkt_lvl words (protocol violation case)");
    inj = 1;
    go(4);
    wait_done(n);
    chk("t6_lvl_or", 32'(bkt_lvl_o), 32'd6);
    chk("t6_found", 32'(found_o), 32'd1);
    chk("t6_unsat", 32'(unsat_o), 32'd0);
    @(posedge clk); #1 inj = 0;

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
